logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit: one opcode-selected gate function (AND, OR, NAND, NOR, XOR, XNOR, NOT, PASS) applied across WIDTH-bit operands.
- Valid/ready handshakes on input and output.
- Optional accumulate mode chains results across a burst.
- Provides result reduction flags; sits between operand sources and any downstream consumer of logic results.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_core.sv | 36 +++
 rtl/logic_unit_pipe.sv | 157 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit: opcode width and
// opcode encodings used by the pipe and its combinational core.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_core.sv
// Purely combinational gate function f(op, a, y) across WIDTH bits, plus the
// {xor, or, and} reduction of the result.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] f_o,
    output logic [2:0]       zr_o
);

    // Opcode-selected bitwise function; NOT and PASS look at a only.
    always_comb begin
        f_o = {WIDTH{1'b0}};
        case (op_i)
            OP_AND:  f_o = a_i & y_i;
            OP_OR:   f_o = a_i | y_i;
            OP_NAND: f_o = ~(a_i & y_i);
            OP_NOR:  f_o = ~(a_i | y_i);
            OP_XOR:  f_o = a_i ^ y_i;
            OP_XNOR: f_o = ~(a_i ^ y_i);
            OP_NOT:  f_o = ~a_i;
            OP_PASS: f_o = a_i;
            default: f_o = a_i;
        endcase
    end

    // Reduction flags of the computed result, registered alongside it.
    always_comb begin
        zr_o = {^f_o, |f_o, &f_o};
    end

endmodule : logic_unit_core

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
// sides and an optional accumulator that chains results across a burst.
// S1 holds the accepted operands; S2 holds the computed result and flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc,
    input  logic             first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [2:0]       zr
);

    // Stage 1 operand registers
    logic             s1_v_q,     s1_v_d;
    logic [OP_W-1:0]  s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_acc_q,   s1_acc_d;
    logic             s1_first_q, s1_first_d;

    // Stage 2 result registers and accumulator
    logic             s2_v_q,  s2_v_d;
    logic [WIDTH-1:0] z_q,     z_d;
    logic [2:0]       zr_q,    zr_d;
    logic [WIDTH-1:0] accum_q, accum_d;

    // Handshake and datapath helpers
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             s2_cap_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] f_s;
    logic [2:0]       f_zr_s;

    // Advance conditions: a stage may take new data when empty or when the
    // stage downstream of it is moving this cycle.
    always_comb begin
        s2_adv_s = !s2_v_q || out_ready;
        s1_adv_s = !s1_v_q || s2_adv_s;
        s2_cap_s = s1_v_q && s2_adv_s;
        in_ready = s1_adv_s;
    end

    // Second operand: the accumulator replaces b only for non-seed accumulate beats.
    always_comb begin
        if (s1_acc_q && !s1_first_q) begin
            y_s = accum_q;
        end else begin
            y_s = s1_b_q;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i (s1_op_q),
        .a_i  (s1_a_q),
        .y_i  (y_s),
        .f_o  (f_s),
        .zr_o (f_zr_s)
    );

    // Stage 1 next state: refill on advance, capture operands only on a transfer.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_acc_d   = s1_acc_q;
        s1_first_d = s1_first_q;
        if (s1_adv_s) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_op_d    = op;
                s1_a_d     = a;
                s1_b_d     = b;
                s1_acc_d   = acc;
                s1_first_d = first;
            end else begin
                s1_op_d = s1_op_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // Stage 2 next state: capture result when S1 moves, accumulator follows
    // every captured acc=1 beat so the next beat in S1 sees it one edge later.
    always_comb begin
        s2_v_d  = s2_v_q;
        z_d     = z_q;
        zr_d    = zr_q;
        accum_d = accum_q;
        if (s2_adv_s) begin
            s2_v_d = s1_v_q;
        end else begin
            s2_v_d = s2_v_q;
        end
        if (s2_cap_s) begin
            z_d  = f_s;
            zr_d = f_zr_s;
            if (s1_acc_q) begin
                accum_d = f_s;
            end else begin
                accum_d = accum_q;
            end
        end else begin
            z_d = z_q;
        end
    end

    // Pipeline state registers; reset drops any in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_op_q    <= {OP_W{1'b0}};
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
            s1_acc_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s2_v_q     <= 1'b0;
            z_q        <= {WIDTH{1'b0}};
            zr_q       <= 3'b000;
            accum_q    <= {WIDTH{1'b0}};
        end else begin
            s1_v_q     <= s1_v_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_acc_q   <= s1_acc_d;
            s1_first_q <= s1_first_d;
            s2_v_q     <= s2_v_d;
            z_q        <= z_d;
            zr_q       <= zr_d;
            accum_q    <= accum_d;
        end
    end

    // Outputs come straight from stage 2 registers.
    always_comb begin
        out_valid = s2_v_q;
        z         = z_q;
        zr        = zr_q;
    end

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random
// traffic, checked against a transaction-level model kept in a queue.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, acc, first, out_valid, out_ready;
    logic [2:0] op;
    logic [7:0] a, b, z;
    logic [2:0] zr;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [2:0] op1;
    logic [0:0] a1, b1, z1;
    logic [2:0] zr1;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc(acc), .first(first),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .zr(zr)
    );

    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .a(a1), .b(b1), .acc(1'b0), .first(1'b0),
        .out_valid(out_valid1), .out_ready(out_ready1), .z(z1), .zr(zr1)
    );

    typedef struct {
        logic [7:0] z;
        int         win;
        bit         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seen_z[$];
    logic [2:0] seen_zr[$];
    logic [7:0] m_acc;
    int         total = 0;
    int         bad = 0;
    int         win = 0;
    int         accepts = 0;
    bit         lat_mode = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] z_prev;
    logic [2:0] zr_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // One clock: called at a negedge with inputs set; samples 1 time unit
    // before the rising edge, updates the model, returns at the next negedge.
    task automatic step();
        exp_t       e;
        logic [7:0] y;
        logic [7:0] r;
        #4;
        win++;
        if (stall_prev) begin
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_z", {24'd0, z}, {24'd0, z_prev});
            check_val("hold_zr", {29'd0, zr}, {29'd0, zr_prev});
        end
        stall_prev = out_valid && !out_ready;
        z_prev = z;
        zr_prev = zr;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("z", {24'd0, z}, {24'd0, e.z});
                check_val("zr", {29'd0, zr}, {29'd0, ^e.z, |e.z, &e.z});
                if (e.lat) check_val("latency", win - e.win, 32'd2);
                seen_z.push_back(z);
                seen_zr.push_back(zr);
            end
        end
        if (in_valid && in_ready) begin
            accepts++;
            y = (acc && !first) ? m_acc : b;
            r = ref_f(op, a, y);
            if (acc) m_acc = r;
            e.z = r;
            e.win = win;
            e.lat = lat_mode;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ac, input logic fi);
        in_valid = 1'b1; op = o; a = x; b = y; acc = ac; first = fi;
        step();
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 32'd1, 32'd0);
        check_val("empty_valid", {31'd0, out_valid}, 32'd0);
        check_val("empty_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic clear_seen();
        seen_z.delete();
        seen_zr.delete();
    endtask

    logic [7:0] sweep_tbl [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};

    initial begin
        int a0;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        acc = 1'b0; first = 1'b0; out_ready = 1'b1; m_acc = 8'h00;
        in_valid1 = 1'b0; op1 = 3'd0; a1 = 1'b0; b1 = 1'b0; out_ready1 = 1'b1;
        #2;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_z", {24'd0, z}, 32'd0);
        check_val("rst_zr", {29'd0, zr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Opcode sweep with latency check
        clear_seen();
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) beat(3'(i), 8'hC5, 8'h3A, 1'b0, 1'b0);
        lat_mode = 1'b0;
        drain();
        check_val("sweep_count", seen_z.size(), 32'd8);
        for (int i = 0; i < 8 && i < seen_z.size(); i++)
            check_val($sformatf("sweep_op%0d", i), {24'd0, seen_z[i]}, {24'd0, sweep_tbl[i]});
        if (seen_zr.size() >= 2) begin
            check_val("sweep_zr_and", {29'd0, seen_zr[0]}, 32'd0);
            check_val("sweep_zr_or", {29'd0, seen_zr[1]}, {29'd0, 3'b011});
        end

        // Backpressure: two accepts fill the pipe, then in_ready drops
        clear_seen();
        out_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 5; i++) beat(3'd7, 8'(8'h10 + i), 8'h00, 1'b0, 1'b0);
        check_val("bp_accepts", accepts - a0, 32'd2);
        #1 check_val("bp_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        drain();
        check_val("bp_count", seen_z.size(), 32'd2);
        if (seen_z.size() == 2) begin
            check_val("bp_first", {24'd0, seen_z[0]}, 32'h10);
            check_val("bp_second", {24'd0, seen_z[1]}, 32'h11);
        end

        // Accumulate XOR chain, back to back
        clear_seen();
        beat(3'd4, 8'h0F, 8'h00, 1'b1, 1'b1);
        beat(3'd4, 8'hF0, 8'h55, 1'b1, 1'b0);
        beat(3'd4, 8'hFF, 8'h55, 1'b1, 1'b0);
        drain();
        check_val("xor_count", seen_z.size(), 32'd3);
        if (seen_z.size() == 3) begin
            check_val("xor_b1", {24'd0, seen_z[0]}, 32'h0F);
            check_val("xor_b2", {24'd0, seen_z[1]}, 32'hFF);
            check_val("xor_b3", {24'd0, seen_z[2]}, 32'h00);
            check_val("xor_zr3", {29'd0, seen_zr[2]}, 32'd0);
        end

        // Accumulate AND with toggling out_ready
        clear_seen();
        in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'hAA; acc = 1'b1; first = 1'b1;
        out_ready = 1'b0;
        step();
        a = 8'h0F; b = 8'h00; first = 1'b0;
        for (int i = 0; i < 6 && accepts >= 0; i++) begin
            out_ready = ~out_ready;
            step();
            if (exp_q.size() == 2 || seen_z.size() > 0) in_valid = 1'b0;
        end
        drain();
        check_val("and_count", seen_z.size(), 32'd2);
        if (seen_z.size() == 2) begin
            check_val("and_b1", {24'd0, seen_z[0]}, 32'hAA);
            check_val("and_b2", {24'd0, seen_z[1]}, 32'h0A);
        end

        // Reset with both stages full, then unseeded accumulate beat
        clear_seen();
        out_ready = 1'b0;
        beat(3'd1, 8'h55, 8'h22, 1'b1, 1'b1);
        beat(3'd1, 8'h80, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_z", {24'd0, z}, 32'd0);
        check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        m_acc = 8'h00;
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("post_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        beat(3'd1, 8'h11, 8'hEE, 1'b1, 1'b0);
        drain();
        check_val("post_rst_count", seen_z.size(), 32'd1);
        if (seen_z.size() == 1) check_val("post_rst_z", {24'd0, seen_z[0]}, 32'h11);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            acc = 1'($urandom_range(0, 1));
            first = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // WIDTH=1 instance
        in_valid1 = 1'b1; op1 = 3'd2; a1 = 1'b1; b1 = 1'b1;
        #4 check_val("w1_ready", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        for (int k = 0; k < 5 && !out_valid1; k++) @(negedge clk);
        check_val("w1_nand_v", {31'd0, out_valid1}, 32'd1);
        check_val("w1_nand_z", {31'd0, z1}, 32'd0);
        check_val("w1_nand_zr", {29'd0, zr1}, 32'd0);
        in_valid1 = 1'b1; op1 = 3'd6; a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        in_valid1 = 1'b0;
        for (int k = 0; k < 5 && !(out_valid1 && z1 == 1'b1); k++) @(negedge clk);
        check_val("w1_not_v", {31'd0, out_valid1}, 32'd1);
        check_val("w1_not_z", {31'd0, z1}, 32'd1);
        check_val("w1_not_zr", {29'd0, zr1}, {29'd0, 3'b111});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_logic_unit_pipe
